// File: rtl/envelope_shaper.sv
`default_nettype none
// ============================================================================
//  Module   : envelope_shaper
//  Brief    : ADSR amplitude envelope for a signed 16-bit sample stream.
//             The Q0.16 gain takes one step per accepted input sample. The
//             shaped sample is registered and carries a one-cycle valid
//             strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module envelope_shaper #(
  parameter logic [15:0] ATTACK_INC    = 16'd64,
  parameter logic [15:0] DECAY_DEC     = 16'd16,
  parameter logic [15:0] SUSTAIN_LEVEL = 16'hC000,
  parameter logic [15:0] RELEASE_DEC   = 16'd8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play_enable,
  input  logic               note_start,
  input  logic               note_done,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic [2:0]         env_state,
  output logic               env_done
);

  // Envelope phases; the encoding is visible on env_state.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [16:0] c_gain_full = 17'h0FFFF;

  logic [15:0]        r_gain;
  logic [2:0]         r_state;

  logic               w_accept;
  logic               w_start;
  logic               w_release;
  logic [15:0]        w_gain_nxt;
  logic [2:0]         w_state_nxt;
  logic               w_done_nxt;
  logic [16:0]        w_attack_sum;
  logic signed [16:0] w_decay_diff;
  logic signed [32:0] w_product;
  logic               w_unused_bits;

  // With play_enable low every input is ignored and the block is frozen.
  assign w_accept  = sample_in_valid & play_enable;
  assign w_start   = note_start & play_enable;
  // note_done only matters while a note is sounding and no start competes.
  assign w_release = note_done & play_enable & ~note_start &
                     ((r_state == S_ATTACK) || (r_state == S_DECAY) ||
                      (r_state == S_SUSTAIN));

  // Widened arithmetic so the saturation tests cannot be fooled by wraparound.
  assign w_attack_sum = {1'b0, r_gain} + {1'b0, ATTACK_INC};
  assign w_decay_diff = $signed({1'b0, r_gain}) - $signed({1'b0, DECAY_DEC});

  // Signed sample times unsigned gain; bits [31:16] give an arithmetic floor.
  assign w_product = $signed({{17{sample_in[15]}}, sample_in}) *
                     $signed({17'd0, r_gain});

  // Bits dropped by the Q0.16 scaling; they are never needed.
  assign w_unused_bits = ^{w_product[32], w_product[15:0]};

  // Next envelope state/gain: events take priority over the per-sample step.
  always_comb begin
    w_gain_nxt  = r_gain;
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    if (w_start) begin
      // Retrigger keeps the present gain so the restart has no click.
      w_state_nxt = S_ATTACK;
    end else if (w_release) begin
      w_state_nxt = S_RELEASE;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_gain_nxt = 16'd0;
        end
        S_ATTACK: begin
          if (w_attack_sum >= c_gain_full) begin
            w_gain_nxt  = 16'hFFFF;
            w_state_nxt = S_DECAY;
          end else begin
            w_gain_nxt = w_attack_sum[15:0];
          end
        end
        S_DECAY: begin
          if (w_decay_diff <= $signed({1'b0, SUSTAIN_LEVEL})) begin
            w_gain_nxt  = SUSTAIN_LEVEL;
            w_state_nxt = S_SUSTAIN;
          end else begin
            w_gain_nxt = r_gain - DECAY_DEC;
          end
        end
        S_SUSTAIN: begin
          w_gain_nxt = r_gain;
        end
        S_RELEASE: begin
          if (r_gain <= RELEASE_DEC) begin
            w_gain_nxt  = 16'd0;
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_gain_nxt = r_gain - RELEASE_DEC;
          end
        end
        default: begin
          // Unreachable encodings fall back to a silent idle envelope.
          w_gain_nxt  = 16'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Envelope state and gain registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gain  <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
    end
  end

  // Output sample, valid strobe and done pulse; sample scaled by pre-edge gain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_out       <= 16'sd0;
      sample_out_valid <= 1'b0;
      env_done         <= 1'b0;
    end else begin
      sample_out_valid <= w_accept;
      env_done         <= w_done_nxt;
      if (w_accept) begin
        sample_out <= w_product[31:16];
      end
    end
  end

  assign env_state = r_state;

endmodule
`default_nettype wire
